// File: rtl/carrier_gen.sv
// carrier_gen
// Programmable carrier generator for the pulse transmitter.
// The high and low phase lengths, the burst length and the idle polarity are
// latched into shadow registers at each period boundary. Changing an input in
// the middle of a period therefore cannot glitch the output.
//
// Ports
//   clk            system clock
//   sys_rst_n      asynchronous active-low reset
//   en             run request (level); deassert = stop at the next period end
//   abort          immediate stop; takes priority over everything else
//   high_duration  active phase length minus 1
//   low_duration   inactive phase length minus 1
//   num_periods    periods per burst; 0 = continuous
//   polarity       idle/inactive level of out; the active level is !polarity
//   out            carrier output (registered)
//   busy           1 while in HIGH or LOW
//   period_done    1-cycle pulse at the end of each full period
//   burst_done     1-cycle pulse when a finite burst completes
//
// state | meaning
// IDLE  | stopped; pol_q follows polarity every cycle
// HIGH  | active phase, hi_q+1 clocks
// LOW   | inactive phase, lo_q+1 clocks; its last cycle is the period end
// HOLD  | finite burst finished; waits for en to drop
module carrier_gen #(
    parameter int TIMER_WIDTH = 12,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   en,
    input  logic                   abort,
    input  logic [TIMER_WIDTH-1:0] high_duration,
    input  logic [TIMER_WIDTH-1:0] low_duration,
    input  logic [CNT_WIDTH-1:0]   num_periods,
    input  logic                   polarity,
    output logic                   out,
    output logic                   busy,
    output logic                   period_done,
    output logic                   burst_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] T_ONE = TIMER_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   C_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0]   pcnt_inc;
    logic [TIMER_WIDTH-1:0] hi_q, hi_d;
    logic [TIMER_WIDTH-1:0] lo_q, lo_d;
    logic [CNT_WIDTH-1:0]   np_q, np_d;
    logic                   pol_q, pol_d;
    logic                   pd_d, bd_d;
    logic                   out_d, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        pcnt_inc = pcnt_q + C_ONE;
        hi_d     = hi_q;
        lo_d     = lo_q;
        np_d     = np_q;
        pol_d    = pol_q;
        pd_d     = 1'b0;
        bd_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                pol_d = polarity;
                if (en) begin
                    state_d = S_HIGH;
                    hi_d    = high_duration;
                    lo_d    = low_duration;
                    np_d    = num_periods;
                    cnt_d   = high_duration;
                    pcnt_d  = '0;
                end
            end
            S_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - T_ONE;
                end else begin
                    state_d = S_LOW;
                    cnt_d   = lo_q;
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - T_ONE;
                end else begin
                    pd_d   = 1'b1;
                    pcnt_d = pcnt_inc;
                    if ((np_q != '0) && (pcnt_inc == np_q)) begin
                        state_d = S_HOLD;
                        bd_d    = 1'b1;
                    end else if (!en) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HIGH;
                        hi_d    = high_duration;
                        lo_d    = low_duration;
                        np_d    = num_periods;
                        pol_d   = polarity;
                        cnt_d   = high_duration;
                    end
                end
            end
            S_HOLD: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort cancels any transition taken above. The inactive level stays
        // the one already latched, so out cannot flip while stopping.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            np_d    = np_q;
            pol_d   = (state_q == S_IDLE) ? polarity : pol_q;
            pd_d    = 1'b0;
            bd_d    = 1'b0;
        end

        // Registering the next-state view keeps out/busy aligned with state_q.
        out_d  = pol_d ^ (state_d == S_HIGH);
        busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pcnt_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            np_q        <= '0;
            pol_q       <= 1'b0;
            out         <= 1'b0;
            busy        <= 1'b0;
            period_done <= 1'b0;
            burst_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            np_q        <= np_d;
            pol_q       <= pol_d;
            out         <= out_d;
            busy        <= busy_d;
            period_done <= pd_d;
            burst_done  <= bd_d;
        end
    end

endmodule
